// File: rtl/branch_scanner.sv
// Forward-skip scanner: walks instruction memory from a CBF to its matching CBB and reports the resume PC.
// One instruction examined per cycle; start is ignored unless idle, and errors stay sticky until clear.
module branch_scanner #(
    parameter int PC_WIDTH    = 16,
    parameter int DEPTH_WIDTH = 8
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                start,
    input  logic [PC_WIDTH-1:0] start_pc,
    input  logic [3:0]          instruction,
    input  logic                clear,
    output logic [PC_WIDTH-1:0] fetch_pc,
    output logic                busy,
    output logic                done,
    output logic [PC_WIDTH-1:0] target_pc,
    output logic                error
);

    localparam logic [3:0]             OP_CBF    = 4'h6;
    localparam logic [3:0]             OP_CBB    = 4'h7;
    localparam logic [PC_WIDTH-1:0]    PC_ONE    = 1;
    localparam logic [DEPTH_WIDTH-1:0] DEPTH_ONE = 1;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        DONE,
        ERROR
    } state_t;

    state_t                 state;
    logic [DEPTH_WIDTH-1:0] depth;

    wire pc_last   = &fetch_pc;
    wire depth_max = &depth;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            fetch_pc  <= '0;
            target_pc <= '0;
            depth     <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            error     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (&start_pc) begin
                            state <= ERROR;
                            error <= 1'b1;
                        end else begin
                            state    <= SCAN;
                            busy     <= 1'b1;
                            fetch_pc <= start_pc + PC_ONE;
                            depth    <= '0;
                        end
                    end
                end
                SCAN: begin
                    if (instruction == OP_CBB && depth == '0) begin
                        state     <= DONE;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        target_pc <= fetch_pc + PC_ONE;
                    end else if ((instruction == OP_CBF && depth_max) || pc_last) begin
                        // Nesting too deep, or no match before the top of memory; never wrap.
                        state <= ERROR;
                        busy  <= 1'b0;
                        error <= 1'b1;
                    end else begin
                        fetch_pc <= fetch_pc + PC_ONE;
                        if (instruction == OP_CBF) begin
                            depth <= depth + DEPTH_ONE;
                        end else if (instruction == OP_CBB) begin
                            depth <= depth - DEPTH_ONE;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                ERROR: begin
                    if (clear) begin
                        state <= IDLE;
                        error <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_branch_scanner.sv
// Directed bench for branch_scanner: default, narrow-PC and narrow-depth instances with behavioural memories.
module tb_branch_scanner;

    localparam logic [3:0] OP_INC = 4'h0;
    localparam logic [3:0] OP_MVR = 4'h4;
    localparam logic [3:0] OP_CBF = 4'h6;
    localparam logic [3:0] OP_CBB = 4'h7;
    localparam logic [3:0] OP_NOP = 4'h8;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   passed = 0;
    int   total  = 0;

    always #5 clock = ~clock;

    // Instance a: PC_WIDTH 16, DEPTH_WIDTH 8
    logic        start_a = 0, clear_a = 0;
    logic [15:0] start_pc_a = 0;
    logic [3:0]  instr_a;
    logic [15:0] fetch_a, target_a;
    logic        busy_a, done_a, error_a;
    logic [3:0]  mem_a [0:63];
    assign instr_a = (fetch_a < 16'd64) ? mem_a[fetch_a[5:0]] : OP_NOP;

    branch_scanner dut_a (
        .clock(clock), .reset(reset), .start(start_a), .start_pc(start_pc_a),
        .instruction(instr_a), .clear(clear_a), .fetch_pc(fetch_a), .busy(busy_a),
        .done(done_a), .target_pc(target_a), .error(error_a)
    );

    // Instance b: PC_WIDTH 4
    logic       start_b = 0, clear_b = 0;
    logic [3:0] start_pc_b = 0;
    logic [3:0] instr_b;
    logic [3:0] fetch_b, target_b;
    logic       busy_b, done_b, error_b;
    logic [3:0] mem_b [0:15];
    assign instr_b = mem_b[fetch_b];

    branch_scanner #(.PC_WIDTH(4), .DEPTH_WIDTH(8)) dut_b (
        .clock(clock), .reset(reset), .start(start_b), .start_pc(start_pc_b),
        .instruction(instr_b), .clear(clear_b), .fetch_pc(fetch_b), .busy(busy_b),
        .done(done_b), .target_pc(target_b), .error(error_b)
    );

    // Instance c: DEPTH_WIDTH 2
    logic        start_c = 0, clear_c = 0;
    logic [15:0] start_pc_c = 0;
    logic [3:0]  instr_c;
    logic [15:0] fetch_c, target_c;
    logic        busy_c, done_c, error_c;
    logic [3:0]  mem_c [0:63];
    assign instr_c = (fetch_c < 16'd64) ? mem_c[fetch_c[5:0]] : OP_NOP;

    branch_scanner #(.PC_WIDTH(16), .DEPTH_WIDTH(2)) dut_c (
        .clock(clock), .reset(reset), .start(start_c), .start_pc(start_pc_c),
        .instruction(instr_c), .clear(clear_c), .fetch_pc(fetch_c), .busy(busy_c),
        .done(done_c), .target_pc(target_c), .error(error_c)
    );

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        #2;
        total++; if (fetch_a !== 16'd0) $display("FAIL reset_fetch got=%0d exp=0", fetch_a); else passed++;
        total++; if (target_a !== 16'd0) $display("FAIL reset_target got=%0d exp=0", target_a); else passed++;
        total++; if ({busy_a, done_a, error_a} !== 3'b000) $display("FAIL reset_flags got=%b exp=000", {busy_a, done_a, error_a}); else passed++;
        total++; if (dut_a.depth !== 8'd0) $display("FAIL reset_depth got=%0d exp=0", dut_a.depth); else passed++;
        @(negedge clock);
        reset = 1'b0;
        tick();
    endtask

    task automatic test_simple_skip();
        start_a = 1; start_pc_a = 16'd10;
        tick();
        start_a = 0;
        for (int i = 0; i < 3; i++) begin
            total++; if (busy_a !== 1'b1 || done_a !== 1'b0) $display("FAIL simple_busy%0d got busy=%b done=%b exp busy=1 done=0", i, busy_a, done_a); else passed++;
            total++; if (fetch_a !== 16'(11 + i)) $display("FAIL simple_fetch%0d got=%0d exp=%0d", i, fetch_a, 11 + i); else passed++;
            tick();
        end
        total++; if (done_a !== 1'b1 || busy_a !== 1'b0) $display("FAIL simple_done got done=%b busy=%b exp done=1 busy=0", done_a, busy_a); else passed++;
        total++; if (target_a !== 16'd14) $display("FAIL simple_target got=%0d exp=14", target_a); else passed++;
        tick();
        total++; if (done_a !== 1'b0 || busy_a !== 1'b0) $display("FAIL simple_idle got done=%b busy=%b exp 0 0", done_a, busy_a); else passed++;
    endtask

    task automatic test_start_while_busy();
        start_a = 1; start_pc_a = 16'd10;
        tick();
        start_a = 0;
        tick();
        start_a = 1; start_pc_a = 16'd40;
        tick();
        start_a = 0;
        total++; if (fetch_a !== 16'd13 || busy_a !== 1'b1) $display("FAIL swb_scan got fetch=%0d busy=%b exp fetch=13 busy=1", fetch_a, busy_a); else passed++;
        tick();
        total++; if (done_a !== 1'b1 || target_a !== 16'd14) $display("FAIL swb_done got done=%b target=%0d exp done=1 target=14", done_a, target_a); else passed++;
        start_a = 1; start_pc_a = 16'd40;
        tick();
        start_a = 0;
        total++; if (busy_a !== 1'b0 || fetch_a === 16'd41) $display("FAIL swb_done_start got busy=%b fetch=%0d exp busy=0 fetch!=41", busy_a, fetch_a); else passed++;
        tick();
        total++; if (busy_a !== 1'b0 || done_a !== 1'b0 || target_a !== 16'd14) $display("FAIL swb_after got busy=%b done=%b target=%0d exp 0 0 14", busy_a, done_a, target_a); else passed++;
    endtask

    task automatic test_nested();
        logic [7:0] exp_depth [0:4];
        exp_depth[0] = 8'd0; exp_depth[1] = 8'd1; exp_depth[2] = 8'd1; exp_depth[3] = 8'd0; exp_depth[4] = 8'd0;
        start_a = 1; start_pc_a = 16'd0;
        tick();
        start_a = 0;
        for (int i = 0; i < 5; i++) begin
            total++; if (busy_a !== 1'b1 || fetch_a !== 16'(i + 1)) $display("FAIL nested_fetch%0d got busy=%b fetch=%0d exp busy=1 fetch=%0d", i, busy_a, fetch_a, i + 1); else passed++;
            total++; if (dut_a.depth !== exp_depth[i]) $display("FAIL nested_depth%0d got=%0d exp=%0d", i, dut_a.depth, exp_depth[i]); else passed++;
            tick();
        end
        total++; if (done_a !== 1'b1 || target_a !== 16'd6) $display("FAIL nested_done got done=%b target=%0d exp done=1 target=6", done_a, target_a); else passed++;
        tick();
    endtask

    task automatic test_reset_mid_scan();
        int n;
        start_a = 1; start_pc_a = 16'd20;
        tick();
        start_a = 0;
        tick(); tick(); tick();
        #2 reset = 1'b1;
        #1;
        total++; if (fetch_a !== 16'd0 || target_a !== 16'd0) $display("FAIL rst_mid_pc got fetch=%0d target=%0d exp 0 0", fetch_a, target_a); else passed++;
        total++; if ({busy_a, done_a, error_a} !== 3'b000) $display("FAIL rst_mid_flags got=%b exp=000", {busy_a, done_a, error_a}); else passed++;
        #2 reset = 1'b0;
        tick(); tick();
        total++; if (done_a !== 1'b0 || busy_a !== 1'b0) $display("FAIL rst_mid_nodone got done=%b busy=%b exp 0 0", done_a, busy_a); else passed++;
        start_a = 1; start_pc_a = 16'd20;
        tick();
        start_a = 0;
        total++; if (dut_a.depth !== 8'd0 || fetch_a !== 16'd21) $display("FAIL rst_rescan_start got depth=%0d fetch=%0d exp 0 21", dut_a.depth, fetch_a); else passed++;
        n = 0;
        while (busy_a === 1'b1 && n < 100) begin
            tick();
            n++;
        end
        total++; if (n !== 21) $display("FAIL rst_rescan_cycles got=%0d exp=21", n); else passed++;
        total++; if (done_a !== 1'b1 || target_a !== 16'd42) $display("FAIL rst_rescan_done got done=%b target=%0d exp 1 42", done_a, target_a); else passed++;
        tick();
    endtask

    task automatic test_unmatched();
        start_b = 1; start_pc_b = 4'd13;
        tick();
        start_b = 0;
        total++; if (busy_b !== 1'b1 || fetch_b !== 4'd14) $display("FAIL unm_scan0 got busy=%b fetch=%0d exp 1 14", busy_b, fetch_b); else passed++;
        tick();
        total++; if (busy_b !== 1'b1 || fetch_b !== 4'd15 || error_b !== 1'b0) $display("FAIL unm_scan1 got busy=%b fetch=%0d err=%b exp 1 15 0", busy_b, fetch_b, error_b); else passed++;
        tick();
        total++; if (error_b !== 1'b1 || busy_b !== 1'b0 || done_b !== 1'b0) $display("FAIL unm_error got err=%b busy=%b done=%b exp 1 0 0", error_b, busy_b, done_b); else passed++;
        start_b = 1; start_pc_b = 4'd2;
        tick();
        start_b = 0;
        total++; if (error_b !== 1'b1 || busy_b !== 1'b0) $display("FAIL unm_sticky got err=%b busy=%b exp 1 0", error_b, busy_b); else passed++;
        clear_b = 1;
        tick();
        clear_b = 0;
        total++; if (error_b !== 1'b0 || busy_b !== 1'b0) $display("FAIL unm_clear got err=%b busy=%b exp 0 0", error_b, busy_b); else passed++;
        start_b = 1; start_pc_b = 4'd2;
        tick();
        start_b = 0;
        total++; if (busy_b !== 1'b1 || fetch_b !== 4'd3) $display("FAIL unm_fresh_scan got busy=%b fetch=%0d exp 1 3", busy_b, fetch_b); else passed++;
        tick();
        total++; if (done_b !== 1'b1 || target_b !== 4'd4) $display("FAIL unm_fresh_done got done=%b target=%0d exp 1 4", done_b, target_b); else passed++;
        tick();
    endtask

    task automatic test_pc_boundaries();
        start_b = 1; start_pc_b = 4'd15;
        tick();
        start_b = 0;
        total++; if (error_b !== 1'b1 || busy_b !== 1'b0) $display("FAIL bnd_allones got err=%b busy=%b exp 1 0", error_b, busy_b); else passed++;
        clear_b = 1;
        tick();
        clear_b = 0;
        mem_b[15] = OP_CBB;
        start_b = 1; start_pc_b = 4'd14;
        tick();
        start_b = 0;
        total++; if (busy_b !== 1'b1 || fetch_b !== 4'd15) $display("FAIL bnd_wrap_scan got busy=%b fetch=%0d exp 1 15", busy_b, fetch_b); else passed++;
        tick();
        total++; if (done_b !== 1'b1 || target_b !== 4'd0 || error_b !== 1'b0) $display("FAIL bnd_wrap_done got done=%b target=%0d err=%b exp 1 0 0", done_b, target_b, error_b); else passed++;
        tick();
    endtask

    task automatic test_depth_overflow();
        start_c = 1; start_pc_c = 16'd0;
        tick();
        start_c = 0;
        tick(); tick(); tick();
        total++; if (busy_c !== 1'b1 || fetch_c !== 16'd4 || dut_c.depth !== 2'd3) $display("FAIL ovf_pre got busy=%b fetch=%0d depth=%0d exp 1 4 3", busy_c, fetch_c, dut_c.depth); else passed++;
        tick();
        total++; if (error_c !== 1'b1 || busy_c !== 1'b0 || done_c !== 1'b0) $display("FAIL ovf_error got err=%b busy=%b done=%b exp 1 0 0", error_c, busy_c, done_c); else passed++;
        total++; if (dut_c.depth !== 2'd3) $display("FAIL ovf_depth got=%0d exp=3", dut_c.depth); else passed++;
        start_c = 1; clear_c = 1; start_pc_c = 16'd0;
        tick();
        start_c = 0; clear_c = 0;
        total++; if (error_c !== 1'b0 || busy_c !== 1'b0) $display("FAIL ovf_clear_wins got err=%b busy=%b exp 0 0", error_c, busy_c); else passed++;
        tick();
        total++; if (busy_c !== 1'b0 || done_c !== 1'b0) $display("FAIL ovf_start_dropped got busy=%b done=%b exp 0 0", busy_c, done_c); else passed++;
    endtask

    initial begin
        for (int i = 0; i < 64; i++) begin
            mem_a[i] = OP_NOP;
            mem_c[i] = OP_NOP;
        end
        for (int i = 0; i < 16; i++) mem_b[i] = OP_NOP;
        mem_a[0] = OP_CBF; mem_a[1] = OP_CBF; mem_a[2] = OP_INC;
        mem_a[3] = OP_CBB; mem_a[4] = OP_MVR; mem_a[5] = OP_CBB;
        mem_a[10] = OP_CBF; mem_a[11] = OP_INC; mem_a[12] = 4'h1; mem_a[13] = OP_CBB;
        mem_a[20] = OP_CBF;
        for (int i = 21; i <= 40; i++) mem_a[i] = OP_INC;
        mem_a[41] = OP_CBB;
        mem_b[2] = OP_CBF; mem_b[3] = OP_CBB;
        mem_b[13] = OP_CBF; mem_b[14] = OP_INC; mem_b[15] = OP_INC;
        for (int i = 1; i <= 4; i++) mem_c[i] = OP_CBF;

        test_reset();
        test_simple_skip();
        test_start_while_busy();
        test_nested();
        test_reset_mid_scan();
        test_unmatched();
        test_pc_boundaries();
        test_depth_overflow();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
